// File: rtl/comp_cascade_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : comp_cascade_seq_if
// Description : Digit-in / word-out handshake bundle for comp_cascade_seq.
// Revision    : 1.0 - initial release
// ============================================================================
interface comp_cascade_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_code;
  logic       out_err;
  logic       busy;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_code, out_err, busy
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_code, out_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/comp_cascade_seq.sv
`default_nettype none
// ============================================================================
// Module      : comp_cascade_seq
// Description : Folds NDIGITS 2-bit digit-compare codes (MSB first) into one
//               word-level magnitude result with an illegal-code flag.
// Revision    : 1.0 - initial release
// ============================================================================
module comp_cascade_seq #(
  parameter int NDIGITS = 4,
  parameter int CNT_W   = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         clr,
  comp_cascade_seq_if.slave bus
);

  localparam logic [0:0]       c_accum = 1'b0;
  localparam logic [0:0]       c_hold  = 1'b1;
  localparam logic [CNT_W-1:0] c_last  = CNT_W'(NDIGITS - 1);
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_acc;
  logic             r_err;
  logic [1:0]       r_out_code;
  logic             r_out_err;

  logic             w_accept;
  logic             w_last;
  logic [1:0]       w_acc_next;
  logic             w_err_next;

  assign w_accept = (r_state == c_accum) && bus.in_valid && !clr;
  assign w_last   = w_accept && (r_cnt == c_last);

  // Only the first non-equal digit may load the accumulator; 11 counts as equal.
  assign w_acc_next = ((r_acc == 2'b00) && ((bus.in_code == 2'b01) || (bus.in_code == 2'b10)))
                      ? bus.in_code : r_acc;
  assign w_err_next = r_err | (bus.in_code == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_accum;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clr) begin
      w_state_next = c_accum;
    end else begin
      case (r_state)
        c_accum: if (w_last)        w_state_next = c_hold;
        c_hold:  if (bus.out_ready) w_state_next = c_accum;
        default:                    w_state_next = c_accum;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (r_state == c_accum);
    bus.out_valid = (r_state == c_hold);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_acc      <= 2'b00;
      r_err      <= 1'b0;
      r_out_code <= 2'b00;
      r_out_err  <= 1'b0;
    end else if (clr) begin
      r_cnt      <= '0;
      r_acc      <= 2'b00;
      r_err      <= 1'b0;
      r_out_code <= 2'b00;
      r_out_err  <= 1'b0;
    end else if (w_last) begin
      // Result includes the final digit; accumulators restart for the next word.
      r_out_code <= w_acc_next;
      r_out_err  <= w_err_next;
      r_cnt      <= '0;
      r_acc      <= 2'b00;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + c_one;
      r_acc <= w_acc_next;
      r_err <= w_err_next;
    end
  end

  assign bus.out_code = r_out_code;
  assign bus.out_err  = r_out_err;
  assign bus.busy     = (r_cnt != '0);

endmodule
`default_nettype wire
